// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared types and default constants for the FIFO write arbiter
//
// Purpose : FSM state encoding and default sizing used by fifo_wr_arbiter.
// Contents: arb_state_e   - IDLE (no owner) / LOCK (owner holds the port)
//           DEF_NUM_REQ   - default requester count
//           DEF_MAX_BURST - default longest locked burst, in beats
package fifo_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_e;

  localparam int DEF_NUM_REQ   = 4;
  localparam int DEF_MAX_BURST = 8;

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational round-robin picker
//
// Purpose : returns the first asserted request at or after ptr, wrapping at N.
// Ports   : req   [N-1:0]  request vector
//           ptr   [IW-1:0] highest-priority index this cycle
//           valid          at least one request asserted
//           idx   [IW-1:0] index of the winning request (0 when none)
module rr_picker #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          valid,
  output logic [IW-1:0] idx
);

  always_comb begin
    int cand;
    valid = 1'b0;
    idx   = '0;
    cand  = 0;
    // Walk outward from ptr; the first hit is latched by the valid flag.
    for (int i = 0; i < N; i++) begin
      cand = (int'(ptr) + i) % N;
      if (!valid && req[IW'(cand)]) begin
        valid = 1'b1;
        idx   = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst-locking write arbiter in front of a sync_fifo
//
// Purpose : merges NUM_REQ beat streams into one FIFO write port. A multi-beat
//           burst locks the port to its owner until req_last or MAX_BURST beats.
// Ports   : clk, rst_n                   clock, async active-low reset
//           req_valid/req_last/req_wdata per-requester beat, burst end, data
//           req_ready                    one-hot (or zero) beat accept
//           enqueue/wdata/is_full        sync_fifo write port
//           grant_id                     current or most recent owner
//           burst_err                    sticky: a burst was cut at MAX_BURST
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int NUM_REQ    = DEF_NUM_REQ,
  parameter  int DATA_WIDTH = 64,
  parameter  int MAX_BURST  = DEF_MAX_BURST,
  localparam int IW         = $clog2(NUM_REQ),
  localparam int CW         = $clog2(MAX_BURST + 1)
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [NUM_REQ-1:0]                  req_valid,
  input  logic [NUM_REQ-1:0]                  req_last,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]                  req_ready,
  output logic                                enqueue,
  output logic [DATA_WIDTH-1:0]               wdata,
  input  logic                                is_full,
  output logic [IW-1:0]                       grant_id,
  output logic                                burst_err
);

  arb_state_e    state_q, state_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IW-1:0] grant_q, grant_d;
  logic [CW-1:0] beat_cnt_q, beat_cnt_d;
  logic          burst_err_q, burst_err_d;

  logic          pick_valid;
  logic [IW-1:0] pick_idx;
  logic [IW-1:0] sel_idx;
  logic          sel_valid;
  logic          sel_last;
  logic          beat;
  logic          burst_end;
  logic [CW-1:0] cnt_inc;

  rr_picker #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_rr_picker (
    .req   (req_valid),
    .ptr   (rr_ptr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      beat_cnt_q  <= '0;
      burst_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      beat_cnt_q  <= beat_cnt_d;
      burst_err_q <= burst_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    beat_cnt_d  = beat_cnt_q;
    burst_err_d = burst_err_q;
    req_ready   = '0;

    // While locked only the owner is eligible; otherwise the picker decides.
    sel_idx   = (state_q == LOCK) ? owner_q : pick_idx;
    sel_valid = (state_q == LOCK) ? req_valid[sel_idx] : pick_valid;
    sel_last  = req_last[sel_idx];

    // rst_n gating keeps the write port quiet the instant reset asserts,
    // without waiting for the registers to settle.
    beat = rst_n && sel_valid && !is_full;

    // An IDLE beat is the first of its burst, so the count starts from zero.
    cnt_inc   = ((state_q == LOCK) ? beat_cnt_q : '0) + CW'(1);
    burst_end = beat && (sel_last || (cnt_inc == CW'(MAX_BURST)));

    if (beat) begin
      req_ready[sel_idx] = 1'b1;
      grant_d            = sel_idx;
      if (burst_end) begin
        state_d    = IDLE;
        beat_cnt_d = '0;
        rr_ptr_d   = (sel_idx == IW'(NUM_REQ - 1)) ? '0 : sel_idx + IW'(1);
        if (!sel_last) begin
          burst_err_d = 1'b1;
        end
      end else begin
        state_d    = LOCK;
        owner_d    = sel_idx;
        beat_cnt_d = cnt_inc;
      end
    end

    enqueue   = beat;
    wdata     = beat ? req_wdata[sel_idx] : '0;
    grant_id  = beat ? sel_idx : grant_q;
    burst_err = burst_err_q;
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - directed vector bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;

  logic             clk;
  logic             rst_n;
  logic [3:0]       req_valid;
  logic [3:0]       req_last;
  logic [3:0][63:0] req_wdata;
  logic [3:0]       req_ready;
  logic             enqueue;
  logic [63:0]      wdata;
  logic             is_full;
  logic [1:0]       grant_id;
  logic             burst_err;

  int checks;
  int failures;

  typedef struct {
    logic [3:0] valid;
    logic [3:0] last;
    logic       full;
    logic [7:0] tag;
    logic [3:0] e_ready;
    logic       e_enq;
    logic [1:0] e_gid;
    logic       e_err;
  } vec_t;

  vec_t vecs[$];

  fifo_wr_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_last  (req_last),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .enqueue   (enqueue),
    .wdata     (wdata),
    .is_full   (is_full),
    .grant_id  (grant_id),
    .burst_err (burst_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] mk(int i, logic [7:0] tag);
    return {8'hA5, 8'(i), 40'h0, tag};
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic drive(logic [3:0] v, logic [3:0] l, logic f, logic [7:0] tag);
    req_valid = v;
    req_last  = l;
    is_full   = f;
    for (int i = 0; i < 4; i++) req_wdata[i] = mk(i, tag);
  endtask

  task automatic add(logic [3:0] v, logic [3:0] l, logic f, logic [7:0] tag,
                     logic [3:0] er, logic ee, logic [1:0] eg, logic eerr);
    vec_t x;
    x.valid = v; x.last = l; x.full = f; x.tag = tag;
    x.e_ready = er; x.e_enq = ee; x.e_gid = eg; x.e_err = eerr;
    vecs.push_back(x);
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    //  valid    last     full tag    ready    enq  gid err
    add(4'b0000, 4'b0000, 0, 8'h01, 4'b0000, 0, 0, 0);
    add(4'b1111, 4'b1111, 1, 8'h02, 4'b0000, 0, 0, 0);
    // all four single-beat requesters: strict rotation 0,1,2,3,0
    add(4'b1111, 4'b1111, 0, 8'h03, 4'b0001, 1, 0, 0);
    add(4'b1111, 4'b1111, 0, 8'h04, 4'b0010, 1, 1, 0);
    add(4'b1111, 4'b1111, 0, 8'h05, 4'b0100, 1, 2, 0);
    add(4'b1111, 4'b1111, 0, 8'h06, 4'b1000, 1, 3, 0);
    add(4'b1111, 4'b1111, 0, 8'h07, 4'b0001, 1, 0, 0);
    // req3 single beat moves the pointer back to 0
    add(4'b1000, 4'b1000, 0, 8'h08, 4'b1000, 1, 3, 0);
    // req0 4-beat burst with req1 waiting, one bubble in the middle
    add(4'b0011, 4'b0000, 0, 8'h09, 4'b0001, 1, 0, 0);
    add(4'b0011, 4'b0000, 0, 8'h0A, 4'b0001, 1, 0, 0);
    add(4'b0010, 4'b0000, 0, 8'h0B, 4'b0000, 0, 0, 0);
    add(4'b0011, 4'b0000, 0, 8'h0C, 4'b0001, 1, 0, 0);
    add(4'b0011, 4'b0001, 0, 8'h0D, 4'b0001, 1, 0, 0);
    add(4'b0010, 4'b0010, 0, 8'h0E, 4'b0010, 1, 1, 0);
    // req2 burst stalled by a full FIFO for three cycles on beat 2
    add(4'b0100, 4'b0000, 0, 8'h0F, 4'b0100, 1, 2, 0);
    add(4'b0101, 4'b0000, 1, 8'h10, 4'b0000, 0, 2, 0);
    add(4'b0101, 4'b0000, 1, 8'h10, 4'b0000, 0, 2, 0);
    add(4'b0101, 4'b0000, 1, 8'h10, 4'b0000, 0, 2, 0);
    add(4'b0101, 4'b0000, 0, 8'h10, 4'b0100, 1, 2, 0);
    add(4'b0100, 4'b0100, 0, 8'h11, 4'b0100, 1, 2, 0);
    // req1 runs 8 beats without last: forced release, error flag, req2 next
    for (int b = 0; b < 8; b++)
      add(4'b0110, 4'b0000, 0, 8'(8'h20 + b), 4'b0010, 1, 1, 0);
    add(4'b0110, 4'b0100, 0, 8'h28, 4'b0100, 1, 2, 1);
    add(4'b0000, 4'b0000, 0, 8'h29, 4'b0000, 0, 2, 1);

    // reset with every requester pushing: outputs must stay quiet
    rst_n = 1'b0;
    drive(4'b1111, 4'b1111, 0, 8'hFF);
    #12;
    chk("rst.ready", 64'(req_ready), 64'h0);
    chk("rst.enqueue", 64'(enqueue), 64'h0);
    chk("rst.wdata", wdata, 64'h0);
    chk("rst.grant_id", 64'(grant_id), 64'h0);
    chk("rst.burst_err", 64'(burst_err), 64'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    for (int k = 0; k < vecs.size(); k++) begin
      drive(vecs[k].valid, vecs[k].last, vecs[k].full, vecs[k].tag);
      @(negedge clk);
      chk($sformatf("v%0d.ready", k), 64'(req_ready), 64'(vecs[k].e_ready));
      chk($sformatf("v%0d.enqueue", k), 64'(enqueue), 64'(vecs[k].e_enq));
      chk($sformatf("v%0d.grant_id", k), 64'(grant_id), 64'(vecs[k].e_gid));
      chk($sformatf("v%0d.burst_err", k), 64'(burst_err), 64'(vecs[k].e_err));
      if (vecs[k].e_enq)
        chk($sformatf("v%0d.wdata", k), wdata, mk(int'(vecs[k].e_gid), vecs[k].tag));
      @(posedge clk);
      #1;
    end

    // req3 burst interrupted by an off-edge reset
    drive(4'b1000, 4'b0000, 0, 8'h40);
    @(negedge clk);
    chk("ar.b1_grant", 64'(grant_id), 64'h3);
    @(posedge clk);
    #1 drive(4'b1001, 4'b0000, 0, 8'h41);
    #2;
    chk("ar.b2_ready", 64'(req_ready), 64'b1000);
    #1 rst_n = 1'b0;
    #1;
    chk("ar.rst_ready", 64'(req_ready), 64'h0);
    chk("ar.rst_enqueue", 64'(enqueue), 64'h0);
    chk("ar.rst_wdata", wdata, 64'h0);
    chk("ar.rst_grant_id", 64'(grant_id), 64'h0);
    chk("ar.rst_burst_err", 64'(burst_err), 64'h0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    drive(4'b1001, 4'b1001, 0, 8'h42);
    @(negedge clk);
    chk("ar.post_grant", 64'(grant_id), 64'h0);
    chk("ar.post_ready", 64'(req_ready), 64'b0001);
    chk("ar.post_wdata", wdata, mk(0, 8'h42));
    @(posedge clk);
    #1 drive(4'b1000, 4'b1000, 0, 8'h43);
    @(negedge clk);
    chk("ar.next_grant", 64'(grant_id), 64'h3);
    chk("ar.next_enqueue", 64'(enqueue), 64'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of write requesters (2..8).
REQ-002 SHALL have parameter DATA_WIDTH, default 64, payload width.
REQ-003 SHALL have parameter MAX_BURST, default 8, maximum beats per locked burst.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port req_valid  input  NUM_REQ  per-requester beat valid.
REQ-007 SHALL have port req_last  input  NUM_REQ  per-requester final beat of burst.
REQ-008 SHALL have port req_wdata  input  NUM_REQ x DATA_WIDTH  per-requester beat data.
REQ-009 SHALL have port req_ready  output  NUM_REQ  beat accepted this cycle (one-hot or zero).
REQ-010 SHALL have port enqueue  output  1  write strobe to downstream sync_fifo.
REQ-011 SHALL have port wdata  output  DATA_WIDTH  write data to sync_fifo.
REQ-012 SHALL have port is_full  input  1  sync_fifo full flag.
REQ-013 SHALL have port grant_id  output  $clog2(NUM_REQ)  current/last owner index.
REQ-014 SHALL have port burst_err  output  1  sticky flag, burst exceeded MAX_BURST.

Function
REQ-015 SHALL implement a two-state FSM: IDLE (no owner), LOCK (owner holds port until its last beat).
REQ-016 In IDLE, SHALL pick the winner combinationally among asserted req_valid, round-robin starting at rr_ptr.
REQ-017 A beat SHALL transfer iff owner/winner req_valid=1 and is_full=0; then req_ready[owner]=1, enqueue=1, wdata=owner data, same cycle (zero latency).
REQ-018 is_full=1 SHALL force enqueue=0 and req_ready=0; the FSM state and owner are held.
REQ-019 IDLE beat with req_last=1 SHALL stay IDLE; with req_last=0 SHALL go to LOCK, owner=winner, beat_cnt=1.
REQ-020 In LOCK, only the owner SHALL be served; other requesters get req_ready=0 regardless of is_full.
REQ-021 Owner dropping req_valid in LOCK SHALL create a bubble (enqueue=0) with lock kept.
REQ-022 LOCK beat with req_last=1 SHALL return to IDLE next cycle.
REQ-023 beat_cnt SHALL increment per LOCK beat; a beat bringing beat_cnt to MAX_BURST without req_last SHALL force return to IDLE and set burst_err.
REQ-024 On every burst end (normal or forced, incl. single-beat in IDLE), rr_ptr SHALL become (owner+1) mod NUM_REQ.
REQ-025 enqueue SHALL never assert while is_full=1; at most one req_ready bit SHALL be set per cycle.
REQ-026 grant_id SHALL show the winner in IDLE when a beat transfers, the owner in LOCK, else hold its last value.

Reset
REQ-027 rst_n=0 SHALL asynchronously force state=IDLE, rr_ptr=0, beat_cnt=0, grant_id=0, burst_err=0.
REQ-028 During reset, req_ready=0, enqueue=0, wdata=0.
REQ-029 Reset mid-burst SHALL abandon the burst; no partial state survives; first post-reset grant starts at index 0.
REQ-030 burst_err SHALL be cleared only by reset.

Structure
REQ-031 A shared package fifo_arb_pkg SHALL hold the FSM state enum (IDLE, LOCK) and default constants for NUM_REQ and MAX_BURST.
REQ-032 Round-robin selection SHALL be a sub-module rr_picker (inputs: request vector, pointer; outputs: valid, index), purely combinational.
REQ-033 The arbiter SHALL connect to sync_fifo unmodified via enqueue/wdata/is_full.

Verification
REQ-034 All four req_valid high with req_last=1 continuously, FIFO never full -> grants 0,1,2,3,0 on successive cycles, one beat each.
REQ-035 Req0 4-beat burst (last on 4th) while req1 valid -> beats 0,0,0,0 then req1 served the following cycle; FIFO read-back order matches.
REQ-036 is_full=1 for 3 cycles during req2 burst beat 2 -> enqueue=0 those cycles, grant_id=2 held, burst resumes with beat 2 data unchanged.
REQ-037 Req1 sends 8 beats, req_last never set, MAX_BURST=8 -> forced release after 8th beat, burst_err=1, next grant to req2 if valid.
REQ-038 rst_n deasserted mid-burst of req3 (asynchronous, off clock edge) -> all outputs 0 immediately; after release, req0 and req3 valid -> req0 granted first.
